// File: rtl/branch_hazard_scoreboard.sv
// Decode-stage hazard unit for branches resolved in ID: tracks in-flight writers
// (EX/MEM/WB), selects per-operand forwarding paths and stalls when a source is not yet ready.
module branch_hazard_scoreboard #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic                     id_is_branch,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_flush,
  input  logic                     cnt_clr,
  output logic                     stall,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } entry_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  entry_t                ex_q, mem_q, wb_q;
  entry_t                new_entry;
  logic [NUM_SRC-1:0]    need_stall;
  logic [2*NUM_SRC-1:0]  sel_raw;

  function automatic logic hit(input entry_t e, input logic [REG_W-1:0] src);
    return e.valid && (e.dest == src);
  endfunction

  // A stalled or flushed decode instruction never becomes a writer; r0 is never tracked.
  always_comb begin
    new_entry.valid   = id_valid & id_regwrite & (id_dest != '0) & ~stall & ~id_flush;
    new_entry.dest    = id_dest;
    new_entry.is_load = id_memread;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    need_stall = '0;
    sel_raw    = '0;
    if (id_valid && id_is_branch) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        // Youngest writer wins: EX before MEM before WB.
        if (hit(ex_q, id_src[i*REG_W +: REG_W])) begin
          need_stall[i] = 1'b1;
        end else if (hit(mem_q, id_src[i*REG_W +: REG_W])) begin
          if (mem_q.is_load) need_stall[i] = 1'b1;
          else               sel_raw[2*i +: 2] = SEL_MEM;
        end else if (hit(wb_q, id_src[i*REG_W +: REG_W])) begin
          sel_raw[2*i +: 2] = SEL_WB;
        end else begin
          sel_raw[2*i +: 2] = SEL_RF;
        end
      end
    end
  end

  always_comb begin
    stall   = |need_stall;
    fwd_sel = stall ? '0 : sel_raw;
  end

  // Stages below ID never stall, so the scoreboard shifts every cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all three stages shift in parallel.
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= new_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                      stall_cnt <= '0;
    else if (cnt_clr)                                stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
